// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared widths, line-index field and FSM encoding for the line memory interface.
package mem_if_pkg;
    localparam int LINE_W       = 256;
    localparam int ADDR_W       = 32;
    localparam int LINE_IDX_LSB = 5;
    localparam int LINE_IDX_MSB = 13;
    localparam int IDX_W        = LINE_IDX_MSB - LINE_IDX_LSB + 1;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;
endpackage

// File: rtl/mem_line_array.sv
// mem_line_array: single-port line store; writes and registered reads happen on the same edge.
module mem_line_array
    import mem_if_pkg::*;
#(
    parameter int DEPTH      = 512,
    parameter int DATA_WIDTH = LINE_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] memory [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb rdata_d = re_i ? memory[idx_i] : rdata_q;

    // The array itself is never reset; only the read register is.
    always_ff @(posedge clk_i) begin
        if (we_i) memory[idx_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/line_memory_responder.sv
// line_memory_responder: serialised cache-line read/write responder with fixed latency,
// one-cycle ack, sticky handshake-violation flag and completed-request counter.
module line_memory_responder
    import mem_if_pkg::*;
#(
    parameter int DATA_WIDTH = LINE_W,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DEPTH      = 512,
    parameter int LATENCY    = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  enable_i,
    input  logic                  write_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  busy_o,
    output logic                  proto_err_o,
    output logic [15:0]           req_count_o
);
    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [15:0]           count_q, count_d;
    logic                  accept, done, mem_we, mem_re;
    logic [IDX_W-1:0]      in_idx, mem_idx;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // With LATENCY=1 the acceptance edge is also the commit edge, so the
    // memory port is fed straight from the inputs rather than the latch.
    always_comb begin
        in_idx    = addr_i[LINE_IDX_MSB:LINE_IDX_LSB];
        accept    = rst_i && state_q == IDLE && enable_i;
        done      = (accept && LATENCY == 1) || (rst_i && state_q == WAIT && cnt_q == 8'd0);
        mem_idx   = state_q == IDLE ? in_idx : idx_q;
        mem_wdata = state_q == IDLE ? data_i : wdata_q;
        mem_we    = done && (state_q == IDLE ? write_i : wr_q);
        mem_re    = done && !(state_q == IDLE ? write_i : wr_q);
        state_d   = state_q == IDLE ? (enable_i ? (LATENCY == 1 ? ACK : WAIT) : IDLE)
                  : state_q == WAIT ? (cnt_q == 8'd0 ? ACK : WAIT) : IDLE;
        cnt_d     = accept ? 8'(LATENCY - 1)
                  : (state_q == WAIT && cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
        idx_d     = accept ? in_idx : idx_q;
        wdata_d   = accept ? data_i : wdata_q;
        wr_d      = accept ? write_i : wr_q;
        ack_d     = done;
        err_d     = err_q || (state_q == WAIT && (!enable_i || in_idx != idx_q || write_i != wr_q));
        count_d   = count_q + 16'(done);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    mem_line_array #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .idx_i   (mem_idx),
        .wdata_i (mem_wdata),
        .rdata_o (data_o)
    );

    assign ack_o       = ack_q;
    assign busy_o      = state_q != IDLE;
    assign proto_err_o = err_q;
    assign req_count_o = count_q;
endmodule

// File: tb/tb_line_memory_responder.sv
// tb_line_memory_responder: directed checks of latency, read/write, aliasing, protocol flag and reset abort.
module tb_line_memory_responder;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [31:0]  addr_i = '0;
    logic [255:0] data_i = '0;
    logic         enable_i = 1'b0;
    logic         write_i = 1'b0;
    logic         ack_o;
    logic [255:0] data_o;
    logic         busy_o;
    logic         proto_err_o;
    logic [15:0]  req_count_o;
    int           n_chk = 0;
    int           n_pass = 0;
    int           lat;
    logic         seen;

    localparam logic [255:0] BEEF = {8{32'hDEADBEEF}};

    line_memory_responder dut (
        .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .data_i(data_i),
        .enable_i(enable_i), .write_i(write_i), .ack_o(ack_o), .data_o(data_o),
        .busy_o(busy_o), .proto_err_o(proto_err_o), .req_count_o(req_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Issue one request, hold it until ack, return edges from acceptance to ack.
    task automatic do_req(input logic [31:0] a, input logic [255:0] d, input logic w, output int l);
        @(negedge clk_i);
        addr_i = a; data_i = d; write_i = w; enable_i = 1'b1;
        @(posedge clk_i);
        l = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            l++;
            @(negedge clk_i);
            if (ack_o) break;
        end
        if (!ack_o) check("ack_timeout", 1'b0, 1'b1);
        enable_i = 1'b0;
    endtask

    initial begin
        dut.u_mem.memory[0] = 256'h5;
        dut.u_mem.memory[2] = 256'h22;
        enable_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ack", ack_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_count", req_count_o, 16'd0);
        check("rst_data", data_o, 256'h0);
        enable_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("idle_after_rst", busy_o, 1'b0);

        do_req(32'h0, '0, 1'b0, lat);
        check("read_latency", 32'(lat), 32'd10);
        check("read_data", data_o, 256'h5);
        check("read_count", req_count_o, 16'd1);
        @(negedge clk_i);
        check("ack_one_cycle", ack_o, 1'b0);
        check("data_held", data_o, 256'h5);

        do_req(32'h20, BEEF, 1'b1, lat);
        check("write_latency", 32'(lat), 32'd10);
        check("write_mem1", dut.u_mem.memory[1], BEEF);
        check("write_data_unchanged", data_o, 256'h5);
        do_req(32'h20, '0, 1'b0, lat);
        check("raw_data", data_o, BEEF);
        check("raw_count", req_count_o, 16'd3);

        do_req(32'h4000, 256'hA, 1'b1, lat);
        check("alias_mem0", dut.u_mem.memory[0], 256'hA);
        do_req(32'h0, '0, 1'b0, lat);
        check("alias_read", data_o, 256'hA);
        check("no_err_yet", proto_err_o, 1'b0);

        // Drop enable in WAIT cycle 3; ack must still arrive on schedule.
        @(negedge clk_i);
        addr_i = 32'h20; write_i = 1'b0; enable_i = 1'b1;
        @(posedge clk_i);
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
            if (lat == 3) begin
                check("err_before_drop", proto_err_o, 1'b0);
                enable_i = 1'b0;
            end
            if (lat == 4) check("err_set", proto_err_o, 1'b1);
            seen = ack_o;
        end
        check("viol_ack_seen", seen, 1'b1);
        check("viol_latency", 32'(lat), 32'd10);
        check("viol_data", data_o, BEEF);
        do_req(32'h0, '0, 1'b0, lat);
        check("err_sticky", proto_err_o, 1'b1);
        check("count_7", req_count_o, 16'd7);

        // Reset in WAIT cycle 5 of a write to line 2.
        @(negedge clk_i);
        addr_i = 32'h40; data_i = 256'hBAD; write_i = 1'b1; enable_i = 1'b1;
        @(posedge clk_i);
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_err", proto_err_o, 1'b0);
        check("mid_rst_count", req_count_o, 16'd0);
        check("mid_rst_data", data_o, 256'h0);
        enable_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            seen |= ack_o;
        end
        check("mid_rst_no_ack", seen, 1'b0);
        check("mid_rst_mem2", dut.u_mem.memory[2], 256'h22);
        do_req(32'h40, '0, 1'b0, lat);
        check("post_rst_read", data_o, 256'h22);
        check("post_rst_count", req_count_o, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
